// File: rtl/alu_reservation_station.sv
// alu_reservation_station
//   Age-ordered reservation station for ALU instructions. Slot 0 holds the
//   oldest entry. An issued entry is removed and every younger entry shifts
//   down one slot. New instructions go into the first free slot after that
//   shift. Writeback broadcasts wake up matching source operands, including
//   operands of entries that shift in the same cycle.
//
// Ports
//   CLK, RST                  clock and synchronous active-high reset
//   dispatch_valid/ready      handshake for incoming instruction
//   dispatch_struct[47:0]     {op[4], itype, src0{needed,ready,tag[6]},
//                              src1{needed,ready,tag[6]}, dest[6], imm16, ROB[5]}
//   WB_valid, WB_phys_reg_tag writeback broadcast
//   flush                     kill every entry
//   issue_valid/ready         handshake toward ALU pipeline
//   issue_*                   fields of the oldest issuable entry
module alu_reservation_station #(
  parameter int RS_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dispatch_valid,
  output logic        dispatch_ready,
  input  logic [47:0] dispatch_struct,
  input  logic        WB_valid,
  input  logic [5:0]  WB_phys_reg_tag,
  input  logic        flush,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [3:0]  issue_op,
  output logic        issue_itype,
  output logic [5:0]  issue_source_0_phys_reg_tag,
  output logic [5:0]  issue_source_1_phys_reg_tag,
  output logic [5:0]  issue_dest_phys_reg_tag,
  output logic [15:0] issue_imm16,
  output logic [4:0]  issue_ROB_index
);

  localparam int CW = $clog2(RS_DEPTH + 1);
  localparam int IW = $clog2(RS_DEPTH);

  // Field order matches dispatch_struct bit-for-bit so a plain cast unpacks it.
  typedef struct packed {
    logic [3:0]  op;
    logic        itype;
    logic        s0_needed;
    logic        s0_ready;
    logic [5:0]  s0_tag;
    logic        s1_needed;
    logic        s1_ready;
    logic [5:0]  s1_tag;
    logic [5:0]  dest;
    logic [15:0] imm16;
    logic [4:0]  rob;
  } entry_t;

  entry_t              entry_reg [RS_DEPTH];
  entry_t              entry_next[RS_DEPTH];
  entry_t              up_entry  [RS_DEPTH];
  logic [RS_DEPTH-1:0] valid_reg, valid_next, up_valid, issuable;
  logic [CW-1:0]       count_reg, count_next, count_after;
  logic [IW-1:0]       issue_idx;
  logic                issue_found, issue_fire, dispatch_fire;
  entry_t              captured;

  // Wakeup of an already stored entry: only needed sources listen.
  function automatic entry_t wake_stored(entry_t e, logic v, logic [5:0] t);
    entry_t r = e;
    if (v && e.s0_needed && e.s0_tag == t) r.s0_ready = 1'b1;
    if (v && e.s1_needed && e.s1_tag == t) r.s1_ready = 1'b1;
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < RS_DEPTH; gi++) begin : g_slot
      // Entry that lands in this slot when something older issues.
      if (gi < RS_DEPTH - 1) begin : g_mid
        assign up_entry[gi] = entry_reg[gi+1];
        assign up_valid[gi] = valid_reg[gi+1];
      end else begin : g_top
        assign up_entry[gi] = '0;
        assign up_valid[gi] = 1'b0;
      end
      // Readiness uses registered state only; a same-cycle WB does not bypass.
      assign issuable[gi] = valid_reg[gi] &&
                            (!entry_reg[gi].s0_needed || entry_reg[gi].s0_ready) &&
                            (!entry_reg[gi].s1_needed || entry_reg[gi].s1_ready);
    end
  endgenerate

  // Oldest issuable entry wins: scan from youngest so the lowest index sticks.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (issuable[i]) begin
        issue_found = 1'b1;
        issue_idx   = IW'(i);
      end
    end
  end

  assign issue_valid    = issue_found && !flush;
  assign dispatch_ready = (count_reg < CW'(RS_DEPTH)) && !flush;
  assign issue_fire     = issue_valid && issue_ready;
  assign dispatch_fire  = dispatch_valid && dispatch_ready;

  assign issue_op                    = entry_reg[issue_idx].op;
  assign issue_itype                 = entry_reg[issue_idx].itype;
  assign issue_source_0_phys_reg_tag = entry_reg[issue_idx].s0_tag;
  assign issue_source_1_phys_reg_tag = entry_reg[issue_idx].s1_tag;
  assign issue_dest_phys_reg_tag     = entry_reg[issue_idx].dest;
  assign issue_imm16                 = entry_reg[issue_idx].imm16;
  assign issue_ROB_index             = entry_reg[issue_idx].rob;

  // A source captured at dispatch is ready if it arrives ready or its tag is
  // being broadcast in the same cycle.
  always_comb begin
    captured = entry_t'(dispatch_struct);
    if (WB_valid && captured.s0_tag == WB_phys_reg_tag) captured.s0_ready = 1'b1;
    if (WB_valid && captured.s1_tag == WB_phys_reg_tag) captured.s1_ready = 1'b1;
  end

  assign count_after = count_reg - CW'(issue_fire);
  assign count_next  = count_after + CW'(dispatch_fire);

  // Collapse first, then wakeup on the shifted contents, then append.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (issue_fire && IW'(i) >= issue_idx) begin
        entry_next[i] = up_entry[i];
        valid_next[i] = up_valid[i];
      end else begin
        entry_next[i] = entry_reg[i];
        valid_next[i] = valid_reg[i];
      end
      entry_next[i] = wake_stored(entry_next[i], WB_valid, WB_phys_reg_tag);
      if (dispatch_fire && CW'(i) == count_after) begin
        entry_next[i] = captured;
        valid_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      count_reg <= count_next;
      valid_reg <= valid_next;
      entry_reg <= entry_next;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
module tb_alu_reservation_station;

  logic        CLK = 1'b0;
  logic        RST;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic [47:0] dispatch_struct;
  logic        WB_valid;
  logic [5:0]  WB_phys_reg_tag;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_op;
  logic        issue_itype;
  logic [5:0]  issue_source_0_phys_reg_tag;
  logic [5:0]  issue_source_1_phys_reg_tag;
  logic [5:0]  issue_dest_phys_reg_tag;
  logic [15:0] issue_imm16;
  logic [4:0]  issue_ROB_index;

  int vectors    = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  alu_reservation_station #(.RS_DEPTH(4)) dut (
    .CLK                         (CLK),
    .RST                         (RST),
    .dispatch_valid              (dispatch_valid),
    .dispatch_ready              (dispatch_ready),
    .dispatch_struct             (dispatch_struct),
    .WB_valid                    (WB_valid),
    .WB_phys_reg_tag             (WB_phys_reg_tag),
    .flush                       (flush),
    .issue_valid                 (issue_valid),
    .issue_ready                 (issue_ready),
    .issue_op                    (issue_op),
    .issue_itype                 (issue_itype),
    .issue_source_0_phys_reg_tag (issue_source_0_phys_reg_tag),
    .issue_source_1_phys_reg_tag (issue_source_1_phys_reg_tag),
    .issue_dest_phys_reg_tag     (issue_dest_phys_reg_tag),
    .issue_imm16                 (issue_imm16),
    .issue_ROB_index             (issue_ROB_index)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one edge; inputs are changed and outputs sampled 2ns after it,
  // then a further 1ns settle before sampling outputs that depend on inputs.
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [47:0] mk(input logic [3:0] op, input logic n0, input logic r0,
                                     input logic [5:0] t0, input logic n1, input logic r1,
                                     input logic [5:0] t1, input logic [5:0] dest,
                                     input logic [4:0] rob);
    return {op, 1'b0, n0, r0, t0, n1, r1, t1, dest, 16'hBEEF, rob};
  endfunction

  task automatic idle();
    dispatch_valid  = 1'b0;
    WB_valid        = 1'b0;
    WB_phys_reg_tag = '0;
    flush           = 1'b0;
    issue_ready     = 1'b0;
  endtask

  task automatic push(input logic [47:0] s);
    dispatch_valid  = 1'b1;
    dispatch_struct = s;
    step();
    dispatch_valid  = 1'b0;
  endtask

  initial begin
    idle();
    dispatch_struct = '0;
    RST = 1'b1;
    step();
    step();
    check("rst_issue_valid", issue_valid, 0);
    RST = 1'b0;
    settle();
    check("rst_dispatch_ready", dispatch_ready, 1);

    // Wakeup by a later writeback: src1 tag 7 arrives two cycles after dispatch.
    push(mk(4'h1, 1, 1, 6'd5, 1, 0, 6'd7, 6'd40, 5'd3));
    check("wb_late_blocked0", issue_valid, 0);
    step();
    WB_valid = 1'b1; WB_phys_reg_tag = 6'd7;
    settle();
    check("wb_late_no_bypass", issue_valid, 0);
    step();
    WB_valid = 1'b0;
    check("wb_late_valid", issue_valid, 1);
    check("wb_late_dest", issue_dest_phys_reg_tag, 40);
    check("wb_late_rob", issue_ROB_index, 3);
    check("wb_late_op", issue_op, 1);
    check("wb_late_src1", issue_source_1_phys_reg_tag, 7);
    check("wb_late_imm", issue_imm16, 16'hBEEF);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    check("wb_late_drained", issue_valid, 0);

    // Writeback in the dispatch cycle is captured with the entry.
    WB_valid = 1'b1; WB_phys_reg_tag = 6'd9;
    push(mk(4'h2, 0, 0, 6'd0, 1, 0, 6'd9, 6'd41, 5'd7));
    WB_valid = 1'b0;
    check("wb_same_valid", issue_valid, 1);
    check("wb_same_rob", issue_ROB_index, 7);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;

    // Fill with four blocked entries, then wake only slot 2.
    for (int i = 0; i < 4; i++)
      push(mk(4'h3, 1, 0, 6'(10 + i), 0, 0, 6'd0, 6'(20 + i), 5'(8 + i)));
    check("full_dispatch_ready", dispatch_ready, 0);
    check("full_issue_valid", issue_valid, 0);
    WB_valid = 1'b1; WB_phys_reg_tag = 6'd12;
    step();
    WB_valid = 1'b0;
    check("slot2_valid", issue_valid, 1);
    check("slot2_rob", issue_ROB_index, 10);
    issue_ready = 1'b1;
    settle();
    check("full_issue_dr_low", dispatch_ready, 0);
    step();
    issue_ready = 1'b0;
    check("collapse_dr_high", dispatch_ready, 1);
    check("collapse_idle", issue_valid, 0);
    WB_valid = 1'b1; WB_phys_reg_tag = 6'd13;
    step();
    check("shifted_rob11", issue_ROB_index, 11);
    WB_phys_reg_tag = 6'd10;
    step();
    WB_valid = 1'b0;
    check("older_wins_rob8", issue_ROB_index, 8);

    // Flush with three entries and concurrent dispatch/issue requests.
    flush = 1'b1; issue_ready = 1'b1; dispatch_valid = 1'b1;
    dispatch_struct = mk(4'h4, 0, 0, 6'd0, 0, 0, 6'd0, 6'd1, 5'd30);
    settle();
    check("flush_issue_valid", issue_valid, 0);
    check("flush_dispatch_ready", dispatch_ready, 0);
    step();
    idle();
    settle();
    check("post_flush_empty", issue_valid, 0);
    check("post_flush_count", dut.count_reg, 0);
    WB_valid = 1'b1; WB_phys_reg_tag = 6'd11;
    step();
    WB_valid = 1'b0;
    check("post_flush_no_ghost", issue_valid, 0);

    // Stalled issue holds the older entry.
    push(mk(4'h5, 0, 0, 6'd0, 0, 0, 6'd0, 6'd2, 5'd1));
    push(mk(4'h6, 0, 0, 6'd0, 0, 0, 6'd0, 6'd3, 5'd4));
    for (int i = 0; i < 3; i++) begin
      check("stall_hold_rob1", issue_ROB_index, 1);
      step();
    end
    issue_ready = 1'b1;
    step();
    check("after_stall_rob4", issue_ROB_index, 4);
    step();
    issue_ready = 1'b0;
    check("after_stall_empty", issue_valid, 0);

    // Issue, writeback and dispatch in the same cycle.
    push(mk(4'h7, 0, 0, 6'd0, 0, 0, 6'd0, 6'd4, 5'd2));
    push(mk(4'h8, 1, 0, 6'd20, 0, 0, 6'd0, 6'd5, 5'd5));
    issue_ready = 1'b1; WB_valid = 1'b1; WB_phys_reg_tag = 6'd20;
    push(mk(4'h9, 0, 0, 6'd0, 0, 0, 6'd0, 6'd6, 5'd6));
    WB_valid = 1'b0; issue_ready = 1'b0;
    check("combo_shift_woken", issue_ROB_index, 5);
    check("combo_shift_valid", issue_valid, 1);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    check("combo_appended", issue_ROB_index, 6);

    // Reset mid-stream with ready entries and a dispatch pending.
    push(mk(4'hA, 0, 0, 6'd0, 0, 0, 6'd0, 6'd7, 5'd12));
    RST = 1'b1; dispatch_valid = 1'b1;
    dispatch_struct = mk(4'hB, 0, 0, 6'd0, 0, 0, 6'd0, 6'd8, 5'd13);
    step();
    dispatch_valid = 1'b0;
    check("rst_mid_issue_valid", issue_valid, 0);
    check("rst_mid_count", dut.count_reg, 0);
    RST = 1'b0;
    settle();
    check("rst_mid_dispatch_ready", dispatch_ready, 1);
    step();
    check("rst_mid_stays_empty", issue_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 4, meaning number of entries (power of 2, >=2).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port CLK  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  synchronous active-high reset.
REQ-005 SHALL have port dispatch_valid  input  1  dispatch unit presents an ALU instruction.
REQ-006 SHALL have port dispatch_ready  output  1  station accepts the instruction this cycle.
REQ-007 SHALL have port dispatch_struct  input  48  ALU_RS_input_struct_t: op, itype, source_0/1 {needed, ready, phys_reg_tag}, dest_phys_reg_tag, imm16, ROB_index.
REQ-008 SHALL have port WB_valid  input  1  writeback broadcast valid.
REQ-009 SHALL have port WB_phys_reg_tag  input  6  phys reg tag that became ready.
REQ-010 SHALL have port flush  input  1  kill all entries (ROB restore/revert).
REQ-011 SHALL have port issue_valid  output  1  an entry is presented to the ALU pipeline.
REQ-012 SHALL have port issue_ready  input  1  ALU pipeline accepts the presented entry.
REQ-013 SHALL have port issue_op  output  4  ALU_op_t of issued entry.
REQ-014 SHALL have port issue_itype  output  1  itype of issued entry.
REQ-015 SHALL have ports issue_source_0_phys_reg_tag, issue_source_1_phys_reg_tag, issue_dest_phys_reg_tag  output  6 each  tags of issued entry.
REQ-016 SHALL have ports issue_imm16 output 16 and issue_ROB_index output 5, fields of issued entry.

Function
REQ-017 SHALL hold entries in age order (slot 0 oldest); each entry stores all dispatch_struct fields plus a valid bit.
REQ-018 SHALL drive dispatch_ready = (valid entry count < RS_DEPTH) AND NOT flush, from registered count only; a full station deasserts dispatch_ready even when an issue fires that cycle.
REQ-019 SHALL accept a dispatch when dispatch_valid AND dispatch_ready, writing it to the youngest free slot (after collapse) on the next edge.
REQ-020 SHALL, on capture, set each source ready bit if the dispatched ready bit is 1 OR (WB_valid AND WB_phys_reg_tag equals that source tag).
REQ-021 SHALL, each cycle WB_valid=1, set the ready bit of every stored needed source whose tag equals WB_phys_reg_tag, on the next edge.
REQ-022 SHALL treat an entry as issuable when valid AND, for each source, (NOT needed OR ready), evaluated on registered state only (no same-cycle WB bypass).
REQ-023 SHALL drive issue_valid and issue_* from the oldest issuable entry combinationally; issue_* are don't-care when issue_valid=0.
REQ-024 SHALL remove the issued entry when issue_valid AND issue_ready, collapsing all younger entries down one slot on the next edge; an unaccepted issue leaves state unchanged and may present a different entry next cycle if an older one becomes issuable.
REQ-025 SHALL handle simultaneous dispatch, WB and issue in one cycle: collapse, append and wakeup all apply, including wakeup of entries that shift slots.
REQ-026 SHALL guarantee minimum latency of 1 cycle: dispatch accepted at edge N -> earliest issue_valid in cycle after edge N.
REQ-027 SHALL, when flush=1, force issue_valid=0 and dispatch_ready=0 that cycle and invalidate all entries on the next edge; flush overrides concurrent dispatch, issue and WB.
REQ-028 SHALL keep count in range 0..RS_DEPTH with no wrap; issue on empty and dispatch on full are impossible by construction.

Reset
REQ-029 SHALL, on RST=1 at an edge, invalidate all entries and set count to 0; RST has priority over flush, dispatch and issue, including mid-operation.
REQ-030 SHALL drive, during and after reset until first dispatch, issue_valid=0 and dispatch_ready=1 (when RST and flush are 0).

Verification
REQ-031 Dispatch ADD src0 tag 5 ready, src1 tag 7 not ready, dest 40, ROB 3; WB tag 7 two cycles later -> issue_valid exactly one cycle after WB with dest 40, ROB 3.
REQ-032 Dispatch with src tag 9 not ready while WB_valid, tag 9 same cycle -> entry stored ready, issue_valid next cycle.
REQ-033 Fill 4 entries all blocked -> dispatch_ready=0; WB wakes slot 2 only -> slot 2 issues, entries 3 collapse, dispatch_ready=1 next cycle, order preserved.
REQ-034 Two issuable entries ROB 1 (older) and ROB 4, issue_ready=0 for 3 cycles then 1 -> issue_ROB_index held at 1, ROB 4 issues following cycle.
REQ-035 3 valid entries, flush asserted with concurrent dispatch_valid and issue_ready -> issue_valid=0 that cycle, station empty next cycle, nothing dispatched.
REQ-036 RST asserted with 2 ready entries mid-stream -> issue_valid=0 next cycle, count 0, dispatch_ready=1 once RST drops.
